// File: rtl/pulse_sync_pkg.sv
// Shared types and default constants for the pulse synchronizer arbiter.
// Width helper keeps down-counter sizing consistent across modules.
package pulse_sync_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        GAP      = 2'd3
    } state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_CNT_W       = 4;
    localparam int DEF_GAP_CYC     = 3;
    localparam int DEF_TIMEOUT_CYC = 255;

    // Bits needed to hold max_val as a down-counter load; never below 1.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans requests starting at ptr_i, wrapping N-1 -> 0.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic             found;

    always_comb begin
        sum     = '0;
        cand    = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(N)) begin
                sum = sum - (IDX_W + 1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_o          = '0;
        gnt_o[win_idx] = found;
    end

    assign idx_o   = win_idx;
    assign valid_o = found;

endmodule

// File: rtl/pulse_sync_arbiter.sv
// Shares one pulse-synchronizer channel among NUM_REQ requesters, queuing events
// per requester in saturating counters and serving them round-robin.
//
// state    | meaning
// IDLE     | channel free; grant next pending requester if any
// ISSUE    | sync_pulse high for this single cycle
// WAIT_ACK | waiting for delivery acknowledge or timeout
// GAP      | enforced idle spacing after each completed event
module pulse_sync_arbiter
    import pulse_sync_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_pulse,
    input  logic                       ack_pulse,
    input  logic                       clear_err,
    output logic                       sync_pulse,
    output logic [$clog2(NUM_REQ)-1:0] sync_id,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         overflow,
    output logic                       timeout
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMO_W = cnt_width(TIMEOUT_CYC - 1);
    localparam int GAP_W = cnt_width(GAP_CYC - 1);

    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    state_e                          state_q, state_d;
    logic [NUM_REQ-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]                 ptr_q, ptr_d;
    logic [ID_W-1:0]                 sync_id_q, sync_id_d;
    logic                            sync_pulse_q, sync_pulse_d;
    logic [TMO_W-1:0]                tmo_q, tmo_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic [NUM_REQ-1:0]              overflow_q, overflow_d;
    logic                            timeout_q, timeout_d;

    logic [NUM_REQ-1:0]              pending;
    logic [NUM_REQ-1:0]              arb_gnt;
    logic [ID_W-1:0]                 arb_idx;
    logic                            arb_valid;
    logic                            grant_en;
    logic                            tmo_hit;
    logic [NUM_REQ-1:0]              ovf_set;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (pending),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        grant_en = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = ISSUE;
                    grant_en = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
                tmo_d   = TMO_LOAD;
            end
            WAIT_ACK: begin
                if (ack_pulse || (tmo_q == '0)) begin
                    // A lost event is dropped, not re-queued; flow resumes as if acked.
                    tmo_hit = !ack_pulse;
                    gap_d   = GAP_LOAD;
                    state_d = (GAP_CYC == 0) ? IDLE : GAP;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_pulse[i] && !(grant_en && arb_gnt[i])) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (!req_pulse[i] && grant_en && arb_gnt[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        sync_id_d = sync_id_q;
        if (grant_en) begin
            ptr_d     = (arb_idx == ID_LAST) ? '0 : arb_idx + ID_W'(1);
            sync_id_d = arb_idx;
        end
    end

    assign sync_pulse_d = (state_d == ISSUE);
    assign overflow_d   = ovf_set | (clear_err ? '0 : overflow_q);
    assign timeout_d    = tmo_hit | (clear_err ? 1'b0 : timeout_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            sync_id_q    <= '0;
            sync_pulse_q <= 1'b0;
            tmo_q        <= '0;
            gap_q        <= '0;
            overflow_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            sync_id_q    <= sync_id_d;
            sync_pulse_q <= sync_pulse_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

    assign sync_pulse = sync_pulse_q;
    assign sync_id    = sync_id_q;
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pulse_sync_arbiter.sv
// Scenario bench for pulse_sync_arbiter: expected grant ids are queued at stimulus
// time and popped by a monitor whenever sync_pulse fires.
module tb_pulse_sync_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_pulse;
    logic       ack_pulse;
    logic       clear_err;
    logic       sync_pulse;
    logic [1:0] sync_id;
    logic       busy;
    logic [3:0] overflow;
    logic       timeout;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [1:0] exp_q[$];
    int         pc_q[$];

    pulse_sync_arbiter #(
        .NUM_REQ     (4),
        .CNT_W       (4),
        .GAP_CYC     (3),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_pulse  (req_pulse),
        .ack_pulse  (ack_pulse),
        .clear_err  (clear_err),
        .sync_pulse (sync_pulse),
        .sync_id    (sync_id),
        .busy       (busy),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every sync_pulse must match the oldest queued id.
    always begin
        @(posedge clk);
        #2;
        if (sync_pulse === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse with sync_id %0d at cycle %0d, required no pulse", sync_id, cyc);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (sync_id !== e) begin
                    n_fail++;
                    $display("FAIL grant_order: got sync_id %0d at cycle %0d, required %0d", sync_id, cyc, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_pulse = '0;
        ack_pulse = 1'b0;
        clear_err = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        exp_q.delete();
        pc_q.delete();
        next_cycle();
    endtask

    // Waits for n pulses (20-cycle bound each), acking ack_dly cycles after each; ack_dly < 0 means never ack.
    task automatic serve(input int n, input int ack_dly, output bit ok);
        bit found;
        ok = 1'b1;
        pc_q.delete();
        for (int k = 0; k < n; k++) begin
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                next_cycle();
                if (sync_pulse === 1'b1) begin
                    found = 1'b1;
                    pc_q.push_back(cyc);
                end
            end
            if (!found) ok = 1'b0;
            if (found && ack_dly >= 0) begin
                repeat (ack_dly) next_cycle();
                ack_pulse = 1'b1;
                next_cycle();
                ack_pulse = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_pulse = '0;
        ack_pulse = 1'b0;
        clear_err = 1'b0;
        repeat (2) next_cycle();
        n_checks++;
        if ({sync_pulse, sync_id, busy, overflow, timeout} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_values: got pulse=%b id=%0d busy=%b ovf=%b tmo=%b, required all zero",
                     sync_pulse, sync_id, busy, overflow, timeout);
        end
        rst_n = 1'b1;
        repeat (3) next_cycle();
        n_checks++;
        if (busy !== 1'b0 || sync_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b pulse=%b, required 0 0", busy, sync_pulse);
        end
    endtask

    task automatic test_single();
        int t0;
        do_reset();
        next_cycle();
        t0 = cyc;
        req_pulse = 4'b0100;
        exp_q.push_back(2'd2);
        goto(t0 + 1);
        req_pulse = '0;
        n_checks++;
        if (sync_pulse !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_n1: got pulse=%b busy=%b, required 0 0", sync_pulse, busy);
        end
        goto(t0 + 2);
        n_checks++;
        if (sync_pulse !== 1'b1 || sync_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_latency: got pulse=%b id=%0d at N+2, required 1 2", sync_pulse, sync_id);
        end
        goto(t0 + 3);
        n_checks++;
        if (sync_pulse !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pulse_width: got pulse=%b busy=%b at N+3, required 0 1", sync_pulse, busy);
        end
        goto(t0 + 5);
        ack_pulse = 1'b1;
        goto(t0 + 6);
        ack_pulse = 1'b0;
        goto(t0 + 8);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gap_busy: got busy=%b at N+8, required 1", busy);
        end
        goto(t0 + 9);
        n_checks++;
        if (busy !== 1'b0 || sync_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b id=%0d at N+9, required 0 2", busy, sync_id);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_drain: got %0d events outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        int t0;
        bit ok;
        do_reset();
        next_cycle();
        t0 = cyc;
        req_pulse = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back(2'(k));
        next_cycle();
        req_pulse = '0;
        serve(4, 2, ok);
        n_checks++;
        if (!ok || pc_q.size() != 4) begin
            n_fail++;
            $display("FAIL rr_serve: got %0d pulses, required 4", pc_q.size());
        end else begin
            n_checks++;
            if (pc_q[0] !== t0 + 2) begin
                n_fail++;
                $display("FAIL rr_first_latency: got cycle %0d, required %0d", pc_q[0], t0 + 2);
            end
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if (pc_q[k] - pc_q[k-1] !== 7) begin
                    n_fail++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles, required 7", k, pc_q[k] - pc_q[k-1]);
                end
            end
        end
        // Pointer wrapped past 3, so requester 0 must beat requester 3.
        req_pulse = 4'b1001;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        next_cycle();
        req_pulse = '0;
        serve(2, 2, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rr_wrap_serve: got %0d pulses, required 2", pc_q.size());
        end
        repeat (2) next_cycle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain: got %0d events outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int t0;
        do_reset();
        next_cycle();
        t0 = cyc;
        req_pulse = 4'b0011;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        goto(t0 + 1);
        req_pulse = '0;
        ack_pulse = 1'b1;
        goto(t0 + 2);
        n_checks++;
        if (sync_pulse !== 1'b1 || sync_id !== 2'd0) begin
            n_fail++;
            $display("FAIL tmo_issue: got pulse=%b id=%0d, required 1 0", sync_pulse, sync_id);
        end
        goto(t0 + 3);
        ack_pulse = 1'b0;
        goto(t0 + 10);
        n_checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_early: got timeout=%b busy=%b in 8th wait cycle, required 0 1", timeout, busy);
        end
        goto(t0 + 11);
        n_checks++;
        if (timeout !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_set: got timeout=%b busy=%b after 8 wait cycles, required 1 1", timeout, busy);
        end
        goto(t0 + 15);
        n_checks++;
        if (sync_pulse !== 1'b1 || sync_id !== 2'd1) begin
            n_fail++;
            $display("FAIL tmo_next_issue: got pulse=%b id=%0d, required 1 1", sync_pulse, sync_id);
        end
        goto(t0 + 17);
        ack_pulse = 1'b1;
        goto(t0 + 18);
        ack_pulse = 1'b0;
        goto(t0 + 20);
        n_checks++;
        if (timeout !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_sticky: got timeout=%b busy=%b, required 1 1", timeout, busy);
        end
        goto(t0 + 21);
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL tmo_end: got busy=%b outstanding=%0d, required 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_same_cycle();
        int t0;
        do_reset();
        next_cycle();
        t0 = cyc;
        req_pulse = 4'b0001;
        exp_q.push_back(2'd0);
        goto(t0 + 1);
        exp_q.push_back(2'd0);
        goto(t0 + 2);
        req_pulse = '0;
        goto(t0 + 4);
        ack_pulse = 1'b1;
        goto(t0 + 5);
        ack_pulse = 1'b0;
        goto(t0 + 9);
        n_checks++;
        if (sync_pulse !== 1'b1 || sync_id !== 2'd0) begin
            n_fail++;
            $display("FAIL same_cycle_second: got pulse=%b id=%0d, required 1 0", sync_pulse, sync_id);
        end
        goto(t0 + 11);
        ack_pulse = 1'b1;
        goto(t0 + 12);
        ack_pulse = 1'b0;
        goto(t0 + 14);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_gap: got busy=%b, required 1", busy);
        end
        goto(t0 + 16);
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL same_cycle_end: got busy=%b outstanding=%0d, required 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        int t0;
        bit ok;
        do_reset();
        next_cycle();
        t0 = cyc;
        // 20 pulses; grants land on cycles 1 and 14, so the counter hits 15
        // on cycle 16 and the pulses of cycles 17..19 are dropped.
        for (int k = 0; k < 20; k++) begin
            goto(t0 + k);
            req_pulse = 4'b0010;
            clear_err = (k == 19);
            if (k < 17) exp_q.push_back(2'd1);
            if (k == 17) begin
                n_checks++;
                if (overflow !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL ovf_not_yet: got overflow=%b, required 0000", overflow);
                end
            end
            if (k == 18) begin
                n_checks++;
                if (overflow !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL ovf_set: got overflow=%b, required 0010", overflow);
                end
            end
        end
        goto(t0 + 20);
        req_pulse = '0;
        clear_err = 1'b1;
        n_checks++;
        if (overflow !== 4'b0010) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got overflow=%b, required 0010", overflow);
        end
        goto(t0 + 21);
        clear_err = 1'b0;
        n_checks++;
        if (overflow !== 4'b0000 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got overflow=%b timeout=%b, required 0000 0", overflow, timeout);
        end
        serve(15, -1, ok);
        n_checks++;
        if (!ok || pc_q.size() != 15) begin
            n_fail++;
            $display("FAIL ovf_drain: got %0d pulses, required 15", pc_q.size());
        end else begin
            n_checks++;
            if (pc_q[0] !== t0 + 28) begin
                n_fail++;
                $display("FAIL ovf_drain_first: got cycle %0d, required %0d", pc_q[0], t0 + 28);
            end
            for (int k = 1; k < 15; k++) begin
                n_checks++;
                if (pc_q[k] - pc_q[k-1] !== 13) begin
                    n_fail++;
                    $display("FAIL ovf_spacing[%0d]: got %0d cycles, required 13", k, pc_q[k] - pc_q[k-1]);
                end
            end
        end
        repeat (2) next_cycle();
        n_checks++;
        if (exp_q.size() != 0 || timeout !== 1'b1 || overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL ovf_end: got outstanding=%0d timeout=%b overflow=%b, required 0 1 0000",
                     exp_q.size(), timeout, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int  t0;
        int  t1;
        int  stray;
        do_reset();
        next_cycle();
        t0 = cyc;
        req_pulse = 4'b1110;
        exp_q.push_back(2'd1);
        goto(t0 + 1);
        req_pulse = 4'b0010;
        goto(t0 + 2);
        req_pulse = '0;
        goto(t0 + 4);
        n_checks++;
        if (busy !== 1'b1 || sync_id !== 2'd1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got busy=%b id=%0d, required 1 1", busy, sync_id);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sync_pulse, sync_id, busy, overflow, timeout} !== 9'b0) begin
            n_fail++;
            $display("FAIL rstmid_values: got pulse=%b id=%0d busy=%b ovf=%b tmo=%b, required all zero",
                     sync_pulse, sync_id, busy, overflow, timeout);
        end
        goto(t0 + 6);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            next_cycle();
            if (sync_pulse !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got %0d active cycles after release, required 0", stray);
        end
        t1 = cyc;
        req_pulse = 4'b1000;
        exp_q.push_back(2'd3);
        goto(t1 + 1);
        req_pulse = '0;
        goto(t1 + 2);
        n_checks++;
        if (sync_pulse !== 1'b1 || sync_id !== 2'd3) begin
            n_fail++;
            $display("FAIL rstmid_new: got pulse=%b id=%0d, required 1 3", sync_pulse, sync_id);
        end
        goto(t1 + 4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_drain: got %0d events outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_same_cycle();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
